port_link_bridge: RTL and testbench
===================================

Name: port_link_bridge

Overview:
- External peer for the drf_system 4-bit port pins. It is the far end of the CPU's port_input/port_output interface.
- Transfers host bytes into the CPU and assembles CPU output into host bytes, using a toggle-handshaked dibit protocol in each direction.
- Sits outside drf_system on the same clock. It drives drf_system.port_input and observes drf_system.port_output.

Parameters:
- IN_REG, 1: number of register stages on in_port_from_drf (0 or 1). Each stage adds 1 cycle of sample latency.
- ACK_TIMEOUT, 0: cycles to wait for a CPU ack before aborting a TX byte. 0 disables the timeout.

Ports:
- clk  input  1  system clock, shared with drf_system
- reset  input  1  synchronous, active-high reset
- in_tx_data  input  8  host byte to send to the CPU
- in_tx_valid  input  1  host offers in_tx_data
- out_tx_ready  output  1  bridge can accept a byte
- out_tx_error  output  1  one-cycle pulse when a TX byte is aborted on timeout
- out_rx_data  output  8  byte assembled from the CPU
- out_rx_valid  output  1  out_rx_data holds a valid byte
- in_rx_ready  input  1  host consumes the byte
- out_port_to_drf  output  4  to drf_system port_input: [3]=tx_req toggle, [2]=rx_ack toggle, [1:0]=tx dibit
- in_port_from_drf  input  4  from drf_system port_output: [3]=rx_req toggle, [2]=tx_ack toggle, [1:0]=rx dibit

Behaviour:
- Reset:
  - out_port_to_drf=0, out_rx_data=0, out_rx_valid=0, out_tx_ready=0, out_tx_error=0.
  - Input sample registers, last_rx_req, counters and shift registers are cleared.
  - out_tx_ready=1 from the first cycle after reset deasserts.
  - Reset mid-byte abandons the byte and returns both FSMs to idle. The CPU program must also restart with port_output=0.
- Byte framing: a byte is 4 dibits, MSB first: [7:6], [5:4], [3:2], [1:0].
- Sampling: all 4 bits of in_port_from_drf are sampled together. Because one CPU port write updates req and data at once, data is coherent with the req toggle.
- TX FSM, states T_IDLE, T_SEND, T_WAIT:
  - T_IDLE: out_tx_ready=1. When in_tx_valid & ready, latch the byte, set idx=0, go to T_SEND.
  - T_SEND (1 cycle): register dibit idx onto [1:0] and toggle [3] in the same cycle. Go to T_WAIT. Data holds until the ack is seen.
  - T_WAIT: when sampled tx_ack == current tx_req:
    - if idx==3, go to T_IDLE;
    - otherwise idx++ and go to T_SEND.
  - Timeout: if ACK_TIMEOUT != 0 and the wait counter reaches ACK_TIMEOUT, pulse out_tx_error, go to T_IDLE, and leave [3] unchanged.
  - A late ack after a timeout is harmless. The next byte toggles req again, and the bridge waits for ack to match the new value.
  - Ack levels are ignored in T_IDLE.
- RX FSM, states R_COLLECT, R_HOLD:
  - R_COLLECT: when sampled rx_req != last_rx_req:
    - shift the dibit in, set last_rx_req=rx_req, toggle [2] (registered, same cycle), cnt++;
    - on the 4th dibit, load out_rx_data, set out_rx_valid=1, go to R_HOLD.
  - R_HOLD: out_rx_valid and out_rx_data are stable. Further req toggles are not consumed or acked (backpressure).
    - When in_rx_ready, clear valid and go to R_COLLECT.
    - A toggle that is already pending is taken on the first R_COLLECT cycle.
- Full duplex: TX and RX are independent. Bits [3] and [1:0] are owned by TX, bit [2] by RX, and they never interact.
- Latency: with IN_REG=1 and an immediate CPU ack, each dibit costs at least 3 cycles (send, sample, observe).

Decomposition:
- Shared package drf_port_link_pkg holds:
  - tx and rx state enums;
  - bit-position constants: REQ=3, ACK=2, DATA_MSB=1, DATA_LSB=0;
  - DIBITS_PER_BYTE=4.
- One sub-module, port_link_rx_deser, contains the RX FSM, shift register and ack toggle. TX stays in the top.

Test Plan:
- Reset for 2 cycles, then release → out_port_to_drf=4'b0000, out_rx_valid=0, out_tx_ready=0 during reset and 1 on the first cycle after.
- TX 0xB4, with a CPU model that acks each toggle 3 cycles later → [1:0] sequence 10,11,01,00; [3] sequence 1,0,1,0; out_tx_ready=1 after the 4th ack.
- RX 0x5A: model writes {req,ack,d} toggling req with dibits 01,01,10,10 → [2] toggles 4 times; out_rx_valid=1 with out_rx_data=0x5A.
- RX backpressure: in_rx_ready=0 and the model toggles the first dibit of 0xC3 → no [2] toggle and 0x5A held; raise ready → dibit acked next R_COLLECT cycle; 0xC3 delivered.
- Full duplex: TX 0xFF and RX 0x00 run concurrently → both complete, with no cross-talk between bits [2] and [3].
- ACK_TIMEOUT=16 with no ack → out_tx_error pulses once at wait cycle 16 and ready returns. Then TX 0x81 with a late stale ack plus correct acks → 0x81 completes. A reset asserted mid-byte returns the bridge to the reset state.

Source files
------------

// File: rtl/drf_port_link_pkg.sv
// Shared types and constants for the drf port link bridge.
// Port nibble layout: [3]=req toggle, [2]=ack toggle, [1:0]=dibit.
package drf_port_link_pkg;

    localparam int unsigned REQ             = 3;
    localparam int unsigned ACK             = 2;
    localparam int unsigned DATA_MSB        = 1;
    localparam int unsigned DATA_LSB        = 0;
    localparam int unsigned DIBITS_PER_BYTE = 4;

    localparam int unsigned PORT_W  = REQ + 1;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned DIBIT_W = DATA_MSB - DATA_LSB + 1;
    localparam int unsigned IDX_W   = $clog2(DIBITS_PER_BYTE);

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_SEND = 2'd1,
        T_WAIT = 2'd2
    } tx_state_t;

    typedef enum logic {
        R_COLLECT = 1'b0,
        R_HOLD    = 1'b1
    } rx_state_t;

    // Field order matches the bit positions above.
    typedef struct packed {
        logic               req;
        logic               ack;
        logic [DIBIT_W-1:0] dibit;
    } port_word_t;

    // Dibit number idx of a byte, MSB dibit first.
    function automatic logic [DIBIT_W-1:0] dibit_at(input logic [BYTE_W-1:0] b,
                                                    input logic [IDX_W-1:0]  idx);
        logic [BYTE_W-1:0] sh;
        sh = b << (DIBIT_W * 32'(idx));
        return sh[BYTE_W-1 -: DIBIT_W];
    endfunction

endpackage

// File: rtl/port_link_rx_deser.sv
// RX side of the port link: consumes req toggles, shifts dibits into a byte,
// acknowledges each dibit and holds the byte until the host takes it.
module port_link_rx_deser
    import drf_port_link_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_req,
    input  logic [DIBIT_W-1:0] rx_dibit,
    input  logic               rx_ready,
    output logic               rx_ack,
    output logic [BYTE_W-1:0]  rx_data,
    output logic               rx_valid
);

    localparam int unsigned SHIFT_W = BYTE_W - DIBIT_W;

    rx_state_t          state;
    logic               last_rx_req;
    logic [SHIFT_W-1:0] shift_q;
    logic [IDX_W-1:0]   cnt;
    logic [BYTE_W-1:0]  next_byte;

    assign next_byte = {shift_q, rx_dibit};

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= R_COLLECT;
            last_rx_req <= 1'b0;
            shift_q     <= '0;
            cnt         <= '0;
            rx_ack      <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
        end else begin
            case (state)
                R_COLLECT: begin
                    if (rx_req != last_rx_req) begin
                        shift_q     <= next_byte[SHIFT_W-1:0];
                        last_rx_req <= rx_req;
                        rx_ack      <= ~rx_ack;
                        cnt         <= cnt + IDX_W'(1);
                        if (cnt == IDX_W'(DIBITS_PER_BYTE - 1)) begin
                            rx_data  <= next_byte;
                            rx_valid <= 1'b1;
                            state    <= R_HOLD;
                        end
                    end
                end
                // Pending toggles wait here unacked until the host drains the byte.
                R_HOLD: begin
                    if (rx_ready) begin
                        rx_valid <= 1'b0;
                        state    <= R_COLLECT;
                    end
                end
                default: state <= R_COLLECT;
            endcase
        end
    end

endmodule

// File: rtl/port_link_bridge.sv
// Host-side peer of the drf_system 4-bit port: byte to dibit TX with toggle
// handshake and optional ack timeout, plus the RX deserializer.
module port_link_bridge
    import drf_port_link_pkg::*;
#(
    parameter int unsigned IN_REG      = 1,
    parameter int unsigned ACK_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] in_tx_data,
    input  logic              in_tx_valid,
    output logic              out_tx_ready,
    output logic              out_tx_error,
    output logic [BYTE_W-1:0] out_rx_data,
    output logic              out_rx_valid,
    input  logic              in_rx_ready,
    output logic [PORT_W-1:0] out_port_to_drf,
    input  logic [PORT_W-1:0] in_port_from_drf
);

    localparam int unsigned WAIT_W     = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic        TIMEOUT_EN = (ACK_TIMEOUT != 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

    port_word_t         port_s;
    port_word_t         port_out;

    tx_state_t          tx_state;
    logic [BYTE_W-1:0]  tx_byte;
    logic [IDX_W-1:0]   tx_idx;
    logic               tx_req;
    logic [DIBIT_W-1:0] tx_dibit;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               rx_ack;

    // All four pins are sampled together so data stays coherent with its req toggle.
    generate
        if (IN_REG != 0) begin : g_in_reg
            logic [PORT_W-1:0] port_q;
            always_ff @(posedge clk) begin
                if (reset) port_q <= '0;
                else       port_q <= in_port_from_drf;
            end
            assign port_s = port_word_t'(port_q);
        end else begin : g_in_direct
            assign port_s = port_word_t'(in_port_from_drf);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state     <= T_IDLE;
            tx_byte      <= '0;
            tx_idx       <= '0;
            tx_req       <= 1'b0;
            tx_dibit     <= '0;
            wait_cnt     <= '0;
            out_tx_ready <= 1'b0;
            out_tx_error <= 1'b0;
        end else begin
            out_tx_error <= 1'b0;
            case (tx_state)
                T_IDLE: begin
                    out_tx_ready <= 1'b1;
                    if (in_tx_valid && out_tx_ready) begin
                        tx_byte      <= in_tx_data;
                        tx_idx       <= '0;
                        out_tx_ready <= 1'b0;
                        tx_state     <= T_SEND;
                    end
                end
                T_SEND: begin
                    tx_dibit <= dibit_at(tx_byte, tx_idx);
                    tx_req   <= ~tx_req;
                    wait_cnt <= '0;
                    tx_state <= T_WAIT;
                end
                // Ack equal to our req level means the CPU took the current dibit.
                T_WAIT: begin
                    if (port_s.ack == tx_req) begin
                        if (tx_idx == IDX_W'(DIBITS_PER_BYTE - 1)) begin
                            out_tx_ready <= 1'b1;
                            tx_state     <= T_IDLE;
                        end else begin
                            tx_idx   <= tx_idx + IDX_W'(1);
                            tx_state <= T_SEND;
                        end
                    end else if (TIMEOUT_EN && (wait_cnt == WAIT_LAST)) begin
                        out_tx_error <= 1'b1;
                        out_tx_ready <= 1'b1;
                        tx_state     <= T_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

    port_link_rx_deser u_rx_deser (
        .clk      (clk),
        .reset    (reset),
        .rx_req   (port_s.req),
        .rx_dibit (port_s.dibit),
        .rx_ready (in_rx_ready),
        .rx_ack   (rx_ack),
        .rx_data  (out_rx_data),
        .rx_valid (out_rx_valid)
    );

    assign port_out        = '{req: tx_req, ack: rx_ack, dibit: tx_dibit};
    assign out_port_to_drf = port_out;

endmodule

// File: tb/tb_port_link_bridge.sv
// Self-checking bench for port_link_bridge with a simple CPU-side port model.
module tb_port_link_bridge;

    localparam int ACK_DLY = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_tx_data;
    logic       in_tx_valid;
    logic       out_tx_ready;
    logic       out_tx_error;
    logic [7:0] out_rx_data;
    logic       out_rx_valid;
    logic       in_rx_ready;
    logic [3:0] out_port_to_drf;
    logic [3:0] in_port_from_drf;

    logic       cpu_req, cpu_ack;
    logic [1:0] cpu_dibit;
    logic       ack_en;
    logic       exp_req, exp_ack;
    logic       mon_prev_req;
    logic [1:0] tx_seen[$];
    logic       req_seen[$];
    int         err_cnt;
    int         tests = 0;
    int         fails = 0;

    typedef struct {
        bit         do_tx;
        logic [7:0] tx_byte;
        bit         do_rx;
        logic [7:0] rx_byte;
        logic [7:0] exp_rx;
    } vec_t;

    assign in_port_from_drf = {cpu_req, cpu_ack, cpu_dibit};

    always #5 clk = ~clk;

    port_link_bridge #(.IN_REG(1), .ACK_TIMEOUT(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_tx_data       (in_tx_data),
        .in_tx_valid      (in_tx_valid),
        .out_tx_ready     (out_tx_ready),
        .out_tx_error     (out_tx_error),
        .out_rx_data      (out_rx_data),
        .out_rx_valid     (out_rx_valid),
        .in_rx_ready      (in_rx_ready),
        .out_port_to_drf  (out_port_to_drf),
        .in_port_from_drf (in_port_from_drf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] ref_dibit(input logic [7:0] b, input int i);
        return 2'((b >> (6 - 2 * i)) & 8'h03);
    endfunction

    // CPU model: follows each req toggle with a matching ack ACK_DLY cycles later.
    initial begin
        int dly;
        dly = 0;
        forever begin
            @(negedge clk);
            if (ack_en && !reset && (out_port_to_drf[3] != cpu_ack)) begin
                dly++;
                if (dly >= ACK_DLY) begin
                    cpu_ack = out_port_to_drf[3];
                    dly = 0;
                end
            end else begin
                dly = 0;
            end
        end
    end

    // Records every TX req toggle together with the dibit presented with it.
    initial begin
        mon_prev_req = 1'b0;
        err_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_prev_req = 1'b0;
            end else begin
                if (out_port_to_drf[3] != mon_prev_req) begin
                    mon_prev_req = out_port_to_drf[3];
                    tx_seen.push_back(out_port_to_drf[1:0]);
                    req_seen.push_back(out_port_to_drf[3]);
                end
                if (out_tx_error) err_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tx_offer(input logic [7:0] b, input string tag);
        int n;
        n = 0;
        while (!out_tx_ready && n < 100) begin @(negedge clk); n++; end
        check($sformatf("%s_ready_before", tag), 32'(out_tx_ready), 32'd1);
        tx_seen.delete();
        req_seen.delete();
        in_tx_data  = b;
        in_tx_valid = 1'b1;
        @(negedge clk);
        in_tx_valid = 1'b0;
        check($sformatf("%s_ready_drop", tag), 32'(out_tx_ready), 32'd0);
    endtask

    task automatic tx_send(input logic [7:0] b, input string tag);
        int n;
        tx_offer(b, tag);
        n = 0;
        while (!out_tx_ready && n < 200) begin @(negedge clk); n++; end
        check($sformatf("%s_tx_done", tag), 32'(out_tx_ready), 32'd1);
        check($sformatf("%s_tx_count", tag), 32'(tx_seen.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            exp_req = ~exp_req;
            if (i < tx_seen.size()) begin
                check($sformatf("%s_dibit%0d", tag, i), 32'(tx_seen[i]), 32'(ref_dibit(b, i)));
                check($sformatf("%s_req%0d", tag, i), 32'(req_seen[i]), 32'(exp_req));
            end
        end
    endtask

    task automatic rx_dibit(input logic [1:0] d, input bit wait_ack, input string tag);
        int n;
        cpu_dibit = d;
        cpu_req   = ~cpu_req;
        if (wait_ack) begin
            exp_ack = ~exp_ack;
            n = 0;
            while (out_port_to_drf[2] != exp_ack && n < 50) begin @(negedge clk); n++; end
            check(tag, 32'(out_port_to_drf[2]), 32'(exp_ack));
        end
    endtask

    task automatic rx_wait_byte(input logic [7:0] exp, input string tag);
        int n;
        n = 0;
        while (!out_rx_valid && n < 20) begin @(negedge clk); n++; end
        check($sformatf("%s_rx_valid", tag), 32'(out_rx_valid), 32'd1);
        check($sformatf("%s_rx_data", tag), 32'(out_rx_data), 32'(exp));
    endtask

    task automatic rx_consume(input string tag);
        in_rx_ready = 1'b1;
        @(negedge clk);
        in_rx_ready = 1'b0;
        check($sformatf("%s_rx_cleared", tag), 32'(out_rx_valid), 32'd0);
    endtask

    task automatic rx_send_byte(input logic [7:0] b, input logic [7:0] exp,
                                input bit consume, input string tag);
        for (int i = 0; i < 4; i++)
            rx_dibit(ref_dibit(b, i), 1'b1, $sformatf("%s_ack%0d", tag, i));
        rx_wait_byte(exp, tag);
        repeat (3) @(negedge clk);
        check($sformatf("%s_rx_hold", tag), 32'({out_rx_valid, out_rx_data}), 32'({1'b1, exp}));
        if (consume) rx_consume(tag);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        fork
            begin
                if (v.do_tx) tx_send(v.tx_byte, tag);
            end
            begin
                if (v.do_rx) rx_send_byte(v.rx_byte, v.exp_rx, 1'b1, tag);
            end
        join
        check($sformatf("%s_req_level", tag), 32'(out_port_to_drf[3]), 32'(exp_req));
        check($sformatf("%s_ack_level", tag), 32'(out_port_to_drf[2]), 32'(exp_ack));
    endtask

    task automatic do_reset(input string tag);
        reset       = 1'b1;
        ack_en      = 1'b0;
        cpu_req     = 1'b0;
        cpu_ack     = 1'b0;
        cpu_dibit   = 2'b00;
        in_tx_valid = 1'b0;
        in_tx_data  = 8'h00;
        in_rx_ready = 1'b0;
        exp_req     = 1'b0;
        exp_ack     = 1'b0;
        @(negedge clk);
        check($sformatf("%s_port", tag), 32'(out_port_to_drf), 32'd0);
        check($sformatf("%s_outs", tag),
              32'({out_rx_valid, out_tx_ready, out_tx_error, out_rx_data}), 32'd0);
        @(negedge clk);
        check($sformatf("%s_ready_in_reset", tag), 32'(out_tx_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check($sformatf("%s_ready_after", tag), 32'(out_tx_ready), 32'd1);
        ack_en = 1'b1;
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;
        int   n;
        int   err0;

        vecs.push_back('{do_tx: 1, tx_byte: 8'hB4, do_rx: 0, rx_byte: 8'h00, exp_rx: 8'h00});
        vecs.push_back('{do_tx: 0, tx_byte: 8'h00, do_rx: 1, rx_byte: 8'h5A, exp_rx: 8'h5A});
        vecs.push_back('{do_tx: 1, tx_byte: 8'hFF, do_rx: 1, rx_byte: 8'h00, exp_rx: 8'h00});
        vecs.push_back('{do_tx: 1, tx_byte: 8'h00, do_rx: 1, rx_byte: 8'hFF, exp_rx: 8'hFF});
        vecs.push_back('{do_tx: 1, tx_byte: 8'h1E, do_rx: 1, rx_byte: 8'h87, exp_rx: 8'h87});

        do_reset("reset");

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: a held byte blocks the next dibit until the host drains it.
        rx_send_byte(8'h5A, 8'h5A, 1'b0, "bp_first");
        rx_dibit(2'b11, 1'b0, "bp_pending");
        repeat (8) @(negedge clk);
        check("bp_no_ack", 32'(out_port_to_drf[2]), 32'(exp_ack));
        check("bp_held", 32'({out_rx_valid, out_rx_data}), 32'({1'b1, 8'h5A}));
        rx_consume("bp");
        exp_ack = ~exp_ack;
        n = 0;
        while (out_port_to_drf[2] != exp_ack && n < 10) begin @(negedge clk); n++; end
        check("bp_ack_latency", 32'(n), 32'd1);
        rx_dibit(2'b00, 1'b1, "bp_ack1");
        rx_dibit(2'b00, 1'b1, "bp_ack2");
        rx_dibit(2'b11, 1'b1, "bp_ack3");
        rx_wait_byte(8'hC3, "bp_second");
        rx_consume("bp_second");

        // Timeout with no CPU ack, then a stale ack and a normal byte.
        ack_en = 1'b0;
        err0 = err_cnt;
        tx_offer(8'h3C, "to");
        exp_req = ~exp_req;
        n = 0;
        while (out_port_to_drf[3] != exp_req && n < 20) begin @(negedge clk); n++; end
        check("to_req_toggle", 32'(out_port_to_drf[3]), 32'(exp_req));
        n = 0;
        while (!out_tx_error && n < 40) begin @(negedge clk); n++; end
        check("to_error_cycle", 32'(n), 32'd16);
        check("to_ready_back", 32'(out_tx_ready), 32'd1);
        @(negedge clk);
        check("to_error_pulse", 32'(out_tx_error), 32'd0);
        repeat (4) @(negedge clk);
        check("to_error_count", 32'(err_cnt - err0), 32'd1);
        check("to_single_toggle", 32'(tx_seen.size()), 32'd1);
        check("to_req_held", 32'(out_port_to_drf[3]), 32'(exp_req));
        cpu_ack = exp_req;
        repeat (4) @(negedge clk);
        check("to_stale_ignored", 32'({out_tx_ready, out_port_to_drf[3]}), 32'({1'b1, exp_req}));
        ack_en = 1'b1;
        v = '{do_tx: 1, tx_byte: 8'h81, do_rx: 0, rx_byte: 8'h00, exp_rx: 8'h00};
        run_vec(v, "after_to");

        // Randomized traffic against the byte-level model.
        for (int i = 0; i < 12; i++) begin
            v.do_tx   = 1'($urandom_range(0, 1));
            v.do_rx   = v.do_tx ? 1'($urandom_range(0, 1)) : 1'b1;
            v.tx_byte = 8'($urandom);
            v.rx_byte = 8'($urandom);
            v.exp_rx  = v.rx_byte;
            run_vec(v, $sformatf("rnd%0d", i));
        end

        // Reset in the middle of a TX byte and a partial RX byte.
        ack_en = 1'b0;
        tx_offer(8'h42, "mid");
        rx_dibit(2'b10, 1'b1, "mid_ack0");
        rx_dibit(2'b01, 1'b1, "mid_ack1");
        do_reset("mid_reset");
        v = '{do_tx: 1, tx_byte: 8'hA5, do_rx: 1, rx_byte: 8'h3C, exp_rx: 8'h3C};
        run_vec(v, "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
